// File: rtl/regfile_access_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// regfile_access_ctrl_pkg
// Shared types and widths for the register-file access controller slice.
//   state_t     : controller FSM encoding (IDLE / READ / WRITE)
//   REG_ADDR_W  : register address width (32 registers)
//   DATA_W      : register data width
//   wb_entry_t  : one buffered writeback {destination register, data}
//   is_r0()     : true when an address names the hard-wired zero register
// ---------------------------------------------------------------------------
package regfile_access_ctrl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     data_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10
    } state_t;

    typedef struct packed {
        reg_addr_t rd;
        data_t     data;
    } wb_entry_t;

    function automatic logic is_r0(input reg_addr_t addr);
        return addr == '0;
    endfunction

endpackage

// File: rtl/regfile_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// regfile_access_ctrl_if
// Bundles the three buses around the access controller:
//   decode read port : rd_req, rd_rs1, rd_rs2 -> rd_ack, rd_data1, rd_data2
//   writeback port   : wb_valid, wb_rd, wb_data -> wb_ready
//   register file    : rf_rsrc1, rf_rsrc2, rf_rdst, rf_in, rf_read -> rf_out1, rf_out2
// Modports:
//   slave  : the controller's view (receives decode/writeback, drives the register file)
//   master : the surrounding pipeline and register file view
// ---------------------------------------------------------------------------
interface regfile_access_ctrl_if
    import regfile_access_ctrl_pkg::*;
();

    logic      rd_req;
    reg_addr_t rd_rs1;
    reg_addr_t rd_rs2;
    logic      rd_ack;
    data_t     rd_data1;
    data_t     rd_data2;

    logic      wb_valid;
    reg_addr_t wb_rd;
    data_t     wb_data;
    logic      wb_ready;

    reg_addr_t rf_rsrc1;
    reg_addr_t rf_rsrc2;
    reg_addr_t rf_rdst;
    data_t     rf_in;
    logic      rf_read;
    data_t     rf_out1;
    data_t     rf_out2;

    modport slave (
        input  rd_req, rd_rs1, rd_rs2,
        output rd_ack, rd_data1, rd_data2,
        input  wb_valid, wb_rd, wb_data,
        output wb_ready,
        output rf_rsrc1, rf_rsrc2, rf_rdst, rf_in, rf_read,
        input  rf_out1, rf_out2
    );

    modport master (
        output rd_req, rd_rs1, rd_rs2,
        input  rd_ack, rd_data1, rd_data2,
        output wb_valid, wb_rd, wb_data,
        input  wb_ready,
        input  rf_rsrc1, rf_rsrc2, rf_rdst, rf_in, rf_read,
        output rf_out1, rf_out2
    );

endinterface

// File: rtl/regfile_access_ctrl_wb_fifo.sv
// ---------------------------------------------------------------------------
// regfile_access_ctrl_wb_fifo
// Small circular buffer of pending writebacks. Besides the usual head/push/pop
// view it exposes every slot and a per-slot valid mask so the controller can
// forward pending write data to operand reads.
// Ports:
//   clk, reset_n         : clock, asynchronous active-low reset (clears all entries)
//   push, push_entry     : enqueue one {rd, data}; ignored when full
//   pop                  : drop the head entry; ignored when empty
//   full, empty          : occupancy flags derived from the registered count
//   head, head_ptr       : oldest entry and its slot index
//   valid                : one bit per slot, set while the slot holds a pending write
//   ent_rd, ent_data     : raw slot contents, indexed by slot
// ---------------------------------------------------------------------------
module regfile_access_ctrl_wb_fifo
    import regfile_access_ctrl_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                push,
    input  wb_entry_t                           push_entry,
    input  logic                                pop,
    output logic                                full,
    output logic                                empty,
    output wb_entry_t                           head,
    output logic [PTR_W-1:0]                    head_ptr,
    output logic [DEPTH-1:0]                    valid,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]    ent_rd,
    output logic [DEPTH-1:0][DATA_W-1:0]        ent_data
);

    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_ptr = rd_ptr;
    assign head     = '{rd: ent_rd[rd_ptr], data: ent_data[rd_ptr]};

    // Slot storage and pointers. DEPTH is a power of two, so the pointers
    // wrap naturally. Push and pop can never hit the same slot in one cycle
    // (push needs !full, pop needs !empty), so the valid updates don't collide.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            valid    <= '0;
            ent_rd   <= '0;
            ent_data <= '0;
        end else begin
            if (do_pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            if (do_push) begin
                ent_rd[wr_ptr]   <= push_entry.rd;
                ent_data[wr_ptr] <= push_entry.data;
                valid[wr_ptr]    <= 1'b1;
                wr_ptr           <= wr_ptr + 1'b1;
            end
        end
    end

    // Occupancy count; a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_access_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_access_ctrl
// Initiator-side controller for a 32 x 32b register file that has a single
// read/write select. Operand reads from decode and result writes from
// writeback share that port: writebacks are buffered in a small FIFO and
// drained one per WRITE cycle, reads take one READ cycle, and pending FIFO
// data is forwarded to reads so decode never sees a stale operand.
// Parameters:
//   WB_DEPTH : writeback FIFO entries (power of two, >= 2)
//   ZERO_R0  : 1 = r0 reads as zero and writes to r0 are discarded
// Ports:
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : slave view of regfile_access_ctrl_if (decode, writeback and
//              register-file signals)
// ---------------------------------------------------------------------------
module regfile_access_ctrl
    import regfile_access_ctrl_pkg::*;
#(
    parameter int WB_DEPTH = 2,
    parameter bit ZERO_R0  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    regfile_access_ctrl_if.slave  bus
);

    localparam int PTR_W = $clog2(WB_DEPTH);

    state_t state;
    state_t next_state;

    logic                                  fifo_push;
    logic                                  fifo_pop;
    logic                                  fifo_full;
    logic                                  fifo_empty;
    wb_entry_t                             push_entry;
    wb_entry_t                             head_entry;
    logic [PTR_W-1:0]                      head_ptr;
    logic [WB_DEPTH-1:0]                   ent_valid;
    logic [WB_DEPTH-1:0][REG_ADDR_W-1:0]   ent_rd;
    logic [WB_DEPTH-1:0][DATA_W-1:0]       ent_data;

    logic             rd_req_live;
    data_t            fwd_data1;
    data_t            fwd_data2;
    logic [PTR_W-1:0] slot;

    // A write to r0 still completes its handshake but never reaches the FIFO.
    assign bus.wb_ready = !fifo_full;
    assign fifo_push    = bus.wb_valid && !fifo_full && !(ZERO_R0 && is_r0(bus.wb_rd));
    assign push_entry   = '{rd: bus.wb_rd, data: bus.wb_data};
    assign fifo_pop     = (state == WRITE);

    // Decode still holds rd_req during the rd_ack cycle; that request has
    // already been served, so it must not start a second READ.
    assign rd_req_live  = bus.rd_req && !bus.rd_ack;

    regfile_access_ctrl_wb_fifo #(
        .DEPTH (WB_DEPTH)
    ) u_wb_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head       (head_entry),
        .head_ptr   (head_ptr),
        .valid      (ent_valid),
        .ent_rd     (ent_rd),
        .ent_data   (ent_data)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decision. A full FIFO always wins so a held read waits at
    // most WB_DEPTH writes; otherwise reads take priority over draining.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (fifo_full) begin
                    next_state = WRITE;
                end else if (rd_req_live) begin
                    next_state = READ;
                end else if (!fifo_empty) begin
                    next_state = WRITE;
                end
            end
            READ:    next_state = IDLE;
            WRITE:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Operand forwarding. Slots are walked oldest to youngest starting at the
    // head, so the last match is the youngest pending write to that register.
    always_comb begin
        fwd_data1 = bus.rf_out1;
        fwd_data2 = bus.rf_out2;
        slot      = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            slot = head_ptr + PTR_W'(i);
            if (ent_valid[slot] && (ent_rd[slot] == bus.rf_rsrc1)) begin
                fwd_data1 = ent_data[slot];
            end
            if (ent_valid[slot] && (ent_rd[slot] == bus.rf_rsrc2)) begin
                fwd_data2 = ent_data[slot];
            end
        end
        if (ZERO_R0 && is_r0(bus.rf_rsrc1)) begin
            fwd_data1 = '0;
        end
        if (ZERO_R0 && is_r0(bus.rf_rsrc2)) begin
            fwd_data2 = '0;
        end
    end

    // Read side: latch the operand addresses when entering READ, capture the
    // forwarded data at the end of READ and acknowledge in the following cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.rf_rsrc1 <= '0;
            bus.rf_rsrc2 <= '0;
            bus.rd_ack   <= 1'b0;
            bus.rd_data1 <= '0;
            bus.rd_data2 <= '0;
        end else begin
            bus.rd_ack <= (state == READ);
            if ((state == IDLE) && (next_state == READ)) begin
                bus.rf_rsrc1 <= bus.rd_rs1;
                bus.rf_rsrc2 <= bus.rd_rs2;
            end
            if (state == READ) begin
                bus.rd_data1 <= fwd_data1;
                bus.rd_data2 <= fwd_data2;
            end
        end
    end

    // Write side: the select and write address/data are all registered so they
    // are stable for the whole WRITE cycle. The FIFO head cannot change while
    // in IDLE, so sampling it on the way into WRITE is safe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.rf_read <= 1'b1;
            bus.rf_rdst <= '0;
            bus.rf_in   <= '0;
        end else begin
            bus.rf_read <= (next_state != WRITE);
            if ((state == IDLE) && (next_state == WRITE)) begin
                bus.rf_rdst <= head_entry.rd;
                bus.rf_in   <= head_entry.data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_regfile_access_ctrl
// Self-checking bench for regfile_access_ctrl (WB_DEPTH=2, ZERO_R0=1).
// A table of per-cycle vectors covers plain reads, a single writeback, the
// youngest-entry forwarding case and r0 handling; hand-written sequences
// cover the full-FIFO starvation bound and reset during WRITE and READ.
// ---------------------------------------------------------------------------
module tb_regfile_access_ctrl;
    import regfile_access_ctrl_pkg::*;

    localparam int WB_DEPTH = 2;
    localparam int NUM_VECS = 20;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    regfile_access_ctrl_if bus ();

    regfile_access_ctrl #(
        .WB_DEPTH (WB_DEPTH),
        .ZERO_R0  (1'b1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // One cycle of stimulus plus the outputs expected after the next edge.
    typedef struct {
        logic        rd_req;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        wb_valid;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic [31:0] out1;
        logic [31:0] out2;
        logic        exp_read;
        logic [4:0]  exp_rdst;
        logic [31:0] exp_in;
        logic [4:0]  exp_rsrc1;
        logic [4:0]  exp_rsrc2;
        logic        exp_ack;
        logic [31:0] exp_d1;
        logic [31:0] exp_d2;
        logic        exp_ready;
    } vec_t;

    vec_t vecs [NUM_VECS];

    int checks = 0;
    int errors = 0;

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive every DUT input from a vector.
    task automatic driveInputs(input vec_t v);
        bus.rd_req   = v.rd_req;
        bus.rd_rs1   = v.rs1;
        bus.rd_rs2   = v.rs2;
        bus.wb_valid = v.wb_valid;
        bus.wb_rd    = v.wb_rd;
        bus.wb_data  = v.wb_data;
        bus.rf_out1  = v.out1;
        bus.rf_out2  = v.out2;
    endtask

    // Quiet inputs: no read request, no writeback.
    task automatic setIdle();
        bus.rd_req   = 1'b0;
        bus.rd_rs1   = '0;
        bus.rd_rs2   = '0;
        bus.wb_valid = 1'b0;
        bus.wb_rd    = '0;
        bus.wb_data  = '0;
        bus.rf_out1  = '0;
        bus.rf_out2  = '0;
    endtask

    // One clock, ending on the falling edge where outputs are sampled.
    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input vec_t v);
        driveInputs(v);
        stepCycle();
    endtask

    task automatic checkVector(input int idx, input vec_t v);
        checkOutput($sformatf("v%0d.rf_read", idx),  32'(bus.rf_read),  32'(v.exp_read));
        checkOutput($sformatf("v%0d.rf_rdst", idx),  32'(bus.rf_rdst),  32'(v.exp_rdst));
        checkOutput($sformatf("v%0d.rf_in", idx),    bus.rf_in,         v.exp_in);
        checkOutput($sformatf("v%0d.rf_rsrc1", idx), 32'(bus.rf_rsrc1), 32'(v.exp_rsrc1));
        checkOutput($sformatf("v%0d.rf_rsrc2", idx), 32'(bus.rf_rsrc2), 32'(v.exp_rsrc2));
        checkOutput($sformatf("v%0d.rd_ack", idx),   32'(bus.rd_ack),   32'(v.exp_ack));
        checkOutput($sformatf("v%0d.rd_data1", idx), bus.rd_data1,      v.exp_d1);
        checkOutput($sformatf("v%0d.rd_data2", idx), bus.rd_data2,      v.exp_d2);
        checkOutput($sformatf("v%0d.wb_ready", idx), 32'(bus.wb_ready), 32'(v.exp_ready));
    endtask

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic got_ack;
        int   writes;

        // Columns: req rs1 rs2 | wbv wbrd wbdata | out1 out2 ||
        //          read rdst in | rsrc1 rsrc2 | ack d1 d2 | ready
        // Simple read: ack two edges after the request, data 7/2.
        vecs[0]  = '{1'b1, 5'd3, 5'd5, 1'b0, 5'd0, 32'h0,  32'h7, 32'h2,
                     1'b1, 5'd0, 32'h0,  5'd3, 5'd5, 1'b0, 32'h0, 32'h0,  1'b1};
        vecs[1]  = '{1'b1, 5'd3, 5'd5, 1'b0, 5'd0, 32'h0,  32'h7, 32'h2,
                     1'b1, 5'd0, 32'h0,  5'd3, 5'd5, 1'b1, 32'h7, 32'h2,  1'b1};
        vecs[2]  = '{1'b1, 5'd3, 5'd5, 1'b0, 5'd0, 32'h0,  32'h7, 32'h2,
                     1'b1, 5'd0, 32'h0,  5'd3, 5'd5, 1'b0, 32'h7, 32'h2,  1'b1};
        // Single writeback r4 <= 0x11, drained by one WRITE cycle.
        vecs[3]  = '{1'b0, 5'd0, 5'd0, 1'b1, 5'd4, 32'h11, 32'h0, 32'h0,
                     1'b1, 5'd0, 32'h0,  5'd3, 5'd5, 1'b0, 32'h7, 32'h2,  1'b1};
        vecs[4]  = '{1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,  32'h0, 32'h0,
                     1'b0, 5'd4, 32'h11, 5'd3, 5'd5, 1'b0, 32'h7, 32'h2,  1'b1};
        vecs[5]  = '{1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,  32'h0, 32'h0,
                     1'b1, 5'd4, 32'h11, 5'd3, 5'd5, 1'b0, 32'h7, 32'h2,  1'b1};
        vecs[6]  = '{1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,  32'h0, 32'h0,
                     1'b1, 5'd4, 32'h11, 5'd3, 5'd5, 1'b0, 32'h7, 32'h2,  1'b1};
        // r4 <= 0xA then r4 <= 0xB; read of r4 must see the younger 0xB.
        vecs[7]  = '{1'b0, 5'd0, 5'd0, 1'b1, 5'd4, 32'hA,  32'h0, 32'h0,
                     1'b1, 5'd4, 32'h11, 5'd3, 5'd5, 1'b0, 32'h7, 32'h2,  1'b1};
        vecs[8]  = '{1'b1, 5'd4, 5'd9, 1'b1, 5'd4, 32'hB,  32'h0, 32'h99,
                     1'b1, 5'd4, 32'h11, 5'd4, 5'd9, 1'b0, 32'h7, 32'h2,  1'b0};
        vecs[9]  = '{1'b1, 5'd4, 5'd9, 1'b0, 5'd0, 32'h0,  32'h0, 32'h99,
                     1'b1, 5'd4, 32'h11, 5'd4, 5'd9, 1'b1, 32'hB, 32'h99, 1'b0};
        vecs[10] = '{1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,  32'h0, 32'h0,
                     1'b0, 5'd4, 32'hA,  5'd4, 5'd9, 1'b0, 32'hB, 32'h99, 1'b0};
        vecs[11] = '{1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,  32'h0, 32'h0,
                     1'b1, 5'd4, 32'hA,  5'd4, 5'd9, 1'b0, 32'hB, 32'h99, 1'b1};
        vecs[12] = '{1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,  32'h0, 32'h0,
                     1'b0, 5'd4, 32'hB,  5'd4, 5'd9, 1'b0, 32'hB, 32'h99, 1'b1};
        vecs[13] = '{1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,  32'h0, 32'h0,
                     1'b1, 5'd4, 32'hB,  5'd4, 5'd9, 1'b0, 32'hB, 32'h99, 1'b1};
        vecs[14] = '{1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,  32'h0, 32'h0,
                     1'b1, 5'd4, 32'hB,  5'd4, 5'd9, 1'b0, 32'hB, 32'h99, 1'b1};
        // r0: write accepted but dropped, read of r0 returns zero.
        vecs[15] = '{1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFF, 32'h0, 32'h0,
                     1'b1, 5'd4, 32'hB,  5'd4, 5'd9, 1'b0, 32'hB, 32'h99, 1'b1};
        vecs[16] = '{1'b1, 5'd0, 5'd4, 1'b0, 5'd0, 32'h0,  32'h55, 32'h22,
                     1'b1, 5'd4, 32'hB,  5'd0, 5'd4, 1'b0, 32'hB, 32'h99, 1'b1};
        vecs[17] = '{1'b1, 5'd0, 5'd4, 1'b0, 5'd0, 32'h0,  32'h55, 32'h22,
                     1'b1, 5'd4, 32'hB,  5'd0, 5'd4, 1'b1, 32'h0, 32'h22, 1'b1};
        vecs[18] = '{1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,  32'h0, 32'h0,
                     1'b1, 5'd4, 32'hB,  5'd0, 5'd4, 1'b0, 32'h0, 32'h22, 1'b1};
        vecs[19] = '{1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,  32'h0, 32'h0,
                     1'b1, 5'd4, 32'hB,  5'd0, 5'd4, 1'b0, 32'h0, 32'h22, 1'b1};

        // Reset and check the reset state.
        setIdle();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        stepCycle();
        stepCycle();
        checkOutput("reset.rf_read",  32'(bus.rf_read),  32'h1);
        checkOutput("reset.rf_rdst",  32'(bus.rf_rdst),  32'h0);
        checkOutput("reset.rf_in",    bus.rf_in,         32'h0);
        checkOutput("reset.rf_rsrc1", 32'(bus.rf_rsrc1), 32'h0);
        checkOutput("reset.rf_rsrc2", 32'(bus.rf_rsrc2), 32'h0);
        checkOutput("reset.rd_ack",   32'(bus.rd_ack),   32'h0);
        checkOutput("reset.rd_data1", bus.rd_data1,      32'h0);
        checkOutput("reset.rd_data2", bus.rd_data2,      32'h0);
        checkOutput("reset.wb_ready", 32'(bus.wb_ready), 32'h1);
        reset_n = 1'b1;

        $display("[TB] running %0d table vectors", NUM_VECS);
        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i]);
            checkVector(i, vecs[i]);
        end

        // Starvation: fill the FIFO, then hold a read. The full FIFO forces
        // WRITE first; the read must still be served within 2*WB_DEPTH+2 cycles
        // and see the still-pending r7 data forwarded.
        $display("[TB] starvation sequence");
        setIdle();
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd6;
        bus.wb_data  = 32'h66;
        stepCycle();
        bus.wb_rd    = 5'd7;
        bus.wb_data  = 32'h77;
        stepCycle();
        writes = 0;
        if (bus.rf_read == 1'b0) writes++;
        checkOutput("starve.wb_ready_full", 32'(bus.wb_ready), 32'h0);
        checkOutput("starve.first_rdst",    32'(bus.rf_rdst),  32'h6);
        checkOutput("starve.first_in",      bus.rf_in,         32'h66);
        setIdle();
        bus.rd_req  = 1'b1;
        bus.rd_rs1  = 5'd7;
        bus.rd_rs2  = 5'd6;
        bus.rf_out1 = 32'h0;
        bus.rf_out2 = 32'h60;
        got_ack = 1'b0;
        for (int c = 0; (c < 2 * WB_DEPTH + 2) && !got_ack; c++) begin
            stepCycle();
            if (bus.rf_read == 1'b0) writes++;
            if (bus.rd_ack == 1'b1) got_ack = 1'b1;
        end
        checkOutput("starve.ack_in_bound", 32'(got_ack), 32'h1);
        checkOutput("starve.rd_data1",     bus.rd_data1, 32'h77);
        checkOutput("starve.rd_data2",     bus.rd_data2, 32'h60);
        checkOutput("starve.writes_before_ack",
                    32'((writes >= 1) && (writes <= WB_DEPTH)), 32'h1);
        setIdle();
        stepCycle();
        checkOutput("starve.drain_read", 32'(bus.rf_read), 32'h0);
        checkOutput("starve.drain_rdst", 32'(bus.rf_rdst), 32'h7);
        checkOutput("starve.drain_in",   bus.rf_in,        32'h77);
        stepCycle();
        checkOutput("starve.done_read",  32'(bus.rf_read),  32'h1);
        checkOutput("starve.done_ready", 32'(bus.wb_ready), 32'h1);

        // Reset while a WRITE is on the bus: select returns to read at once
        // and the queued write is lost.
        $display("[TB] reset during WRITE");
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd9;
        bus.wb_data  = 32'h99;
        stepCycle();
        setIdle();
        stepCycle();
        checkOutput("rstw.in_write", 32'(bus.rf_read), 32'h0);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("rstw.rf_read_async", 32'(bus.rf_read),  32'h1);
        checkOutput("rstw.wb_ready",      32'(bus.wb_ready), 32'h1);
        checkOutput("rstw.rf_rdst",       32'(bus.rf_rdst),  32'h0);
        stepCycle();
        reset_n = 1'b1;
        stepCycle();
        checkOutput("rstw.after1_read", 32'(bus.rf_read), 32'h1);
        checkOutput("rstw.after1_ack",  32'(bus.rd_ack),  32'h0);
        stepCycle();
        checkOutput("rstw.after2_read", 32'(bus.rf_read), 32'h1);

        // Reset while a READ is in flight: no rd_ack may follow.
        $display("[TB] reset during READ");
        bus.rd_req  = 1'b1;
        bus.rd_rs1  = 5'd1;
        bus.rd_rs2  = 5'd2;
        bus.rf_out1 = 32'h1234;
        bus.rf_out2 = 32'h5678;
        stepCycle();
        checkOutput("rstr.in_read_rsrc1", 32'(bus.rf_rsrc1), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        setIdle();
        checkOutput("rstr.rsrc1_cleared", 32'(bus.rf_rsrc1), 32'h0);
        stepCycle();
        reset_n = 1'b1;
        stepCycle();
        checkOutput("rstr.after1_ack",   32'(bus.rd_ack), 32'h0);
        checkOutput("rstr.after1_data1", bus.rd_data1,    32'h0);
        stepCycle();
        checkOutput("rstr.after2_ack",   32'(bus.rd_ack), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
